// File: rtl/nand_cmd_seq.sv
// NAND command/address cycle sequencer: expands one request into CLE/ALE
// qualified bus cycles with programmable WE_n low/high widths.
module nand_cmd_seq #(
   parameter int DW          = 8,
   parameter int ADDR_CYCLES = 5,
   parameter int WE_LOW      = 2,
   parameter int WE_HIGH     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [7:0]               req_cmd1,
   input  logic [7:0]               req_cmd2,
   input  logic [8*ADDR_CYCLES-1:0] req_addr,
   output logic [DW-1:0]            dq_out,
   output logic                     dq_oe,
   output logic                     cle,
   output logic                     ale,
   output logic                     we_n,
   output logic                     ce_n,
   output logic                     done
);

   localparam int T  = WE_LOW + WE_HIGH;
   localparam int PW = (T > 1) ? $clog2(T) : 1;
   localparam int BW = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;

   localparam logic [PW-1:0] PH_LAST  = PW'(T - 1);
   localparam logic [PW-1:0] PH_WE_HI = PW'(WE_LOW);
   localparam logic [BW-1:0] BY_LAST  = BW'(ADDR_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD1 = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_CMD2 = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [1:0] OP_CMD     = 2'd0;
   localparam logic [1:0] OP_ADDR    = 2'd1;
   localparam logic [1:0] OP_ADDR_C2 = 2'd2;
   localparam logic [1:0] OP_RESET   = 2'd3;

   logic [2:0]               state_q, state_d;
   logic [PW-1:0]            phase_q, phase_d;
   logic [BW-1:0]            byte_q, byte_d;
   logic [1:0]               op_q, op_d;
   logic [7:0]               cmd1_q, cmd1_d;
   logic [7:0]               cmd2_q, cmd2_d;
   logic [8*ADDR_CYCLES-1:0] addr_q, addr_d;

   logic                     req_ready_q, req_ready_d;
   logic [DW-1:0]            dq_out_q, dq_out_d;
   logic                     dq_oe_q, dq_oe_d;
   logic                     cle_q, cle_d;
   logic                     ale_q, ale_d;
   logic                     we_n_q, we_n_d;
   logic                     ce_n_q, ce_n_d;
   logic                     done_q, done_d;

   logic [7:0]               addr_bytes [ADDR_CYCLES];
   logic [7:0]               bus_byte;
   logic                     busy_d;
   logic                     byte_end;

   // Address bytes are taken from the next-state capture so the first ADDR
   // byte is correct on the very cycle it is presented.
   generate
      for (genvar gi = 0; gi < ADDR_CYCLES; gi++) begin : g_addr_bytes
         assign addr_bytes[gi] = addr_d[8*gi +: 8];
      end
   endgenerate

   assign byte_end = (phase_q == PH_LAST);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      byte_d  = byte_q;
      op_d    = op_q;
      cmd1_d  = cmd1_q;
      cmd2_d  = cmd2_q;
      addr_d  = addr_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               cmd1_d  = (req_op == OP_RESET) ? 8'hFF : req_cmd1;
               cmd2_d  = req_cmd2;
               addr_d  = req_addr;
               state_d = S_CMD1;
               phase_d = '0;
               byte_d  = '0;
            end
         end
         S_CMD1: begin
            if (byte_end) begin
               phase_d = '0;
               byte_d  = '0;
               if (op_q == OP_ADDR || op_q == OP_ADDR_C2) begin
                  state_d = S_ADDR;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         S_ADDR: begin
            if (byte_end) begin
               phase_d = '0;
               if (byte_q == BY_LAST) begin
                  byte_d  = '0;
                  state_d = (op_q == OP_ADDR_C2) ? S_CMD2 : S_DONE;
               end else begin
                  byte_d = byte_q + BW'(1);
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         S_CMD2: begin
            if (byte_end) begin
               phase_d = '0;
               byte_d  = '0;
               state_d = S_DONE;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            phase_d = '0;
            byte_d  = '0;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
            byte_d  = '0;
         end
      endcase
   end

   // Outputs are a function of the next state so they register cleanly.
   always_comb begin
      busy_d = (state_d == S_CMD1) || (state_d == S_ADDR) || (state_d == S_CMD2);

      bus_byte = 8'h00;
      case (state_d)
         S_CMD1:  bus_byte = cmd1_d;
         S_ADDR:  bus_byte = addr_bytes[byte_d];
         S_CMD2:  bus_byte = cmd2_d;
         default: bus_byte = 8'h00;
      endcase

      dq_out_d      = '0;
      dq_out_d[7:0] = bus_byte;

      req_ready_d = (state_d == S_IDLE);
      done_d      = (state_d == S_DONE);
      ce_n_d      = !busy_d;
      dq_oe_d     = busy_d;
      cle_d       = (state_d == S_CMD1) || (state_d == S_CMD2);
      ale_d       = (state_d == S_ADDR);
      we_n_d      = !(busy_d && (phase_d < PH_WE_HI));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         byte_q      <= '0;
         op_q        <= OP_CMD;
         cmd1_q      <= 8'h00;
         cmd2_q      <= 8'h00;
         addr_q      <= '0;
         req_ready_q <= 1'b1;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         cle_q       <= 1'b0;
         ale_q       <= 1'b0;
         we_n_q      <= 1'b1;
         ce_n_q      <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         byte_q      <= byte_d;
         op_q        <= op_d;
         cmd1_q      <= cmd1_d;
         cmd2_q      <= cmd2_d;
         addr_q      <= addr_d;
         req_ready_q <= req_ready_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         cle_q       <= cle_d;
         ale_q       <= ale_d;
         we_n_q      <= we_n_d;
         ce_n_q      <= ce_n_d;
         done_q      <= done_d;
      end
   end

   assign req_ready = req_ready_q;
   assign dq_out    = dq_out_q;
   assign dq_oe     = dq_oe_q;
   assign cle       = cle_q;
   assign ale       = ale_q;
   assign we_n      = we_n_q;
   assign ce_n      = ce_n_q;
   assign done      = done_q;

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Bench for nand_cmd_seq: two configurations driven with shared requests and
// checked every cycle against a queue of expected bus states.
module tb_nand_cmd_seq;

   typedef logic [22:0] vec_t;   // {ready, ce_n, we_n, cle, ale, oe, done, dq[15:0]}
   typedef vec_t vq_t[$];

   localparam vec_t IDLE_V = {7'b1110000, 16'h0000};
   localparam vec_t DONE_V = {7'b0110001, 16'h0000};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic [7:0]  req_cmd1 = 8'h00;
   logic [7:0]  req_cmd2 = 8'h00;
   logic [39:0] req_addr = 40'h0;

   logic        ready0, oe0, cle0, ale0, we_n0, ce_n0, done0;
   logic [7:0]  dq0;
   logic        ready1, oe1, cle1, ale1, we_n1, ce_n1, done1;
   logic [15:0] dq1;

   int n_chk = 0;
   int n_fail = 0;
   bit run_chk = 1'b0;

   vq_t  q0, q1;
   vec_t exp0 = IDLE_V;
   vec_t exp1 = IDLE_V;
   logic [9:0] lat_q[$];

   nand_cmd_seq #(.DW(8), .ADDR_CYCLES(5), .WE_LOW(2), .WE_HIGH(2)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
      .req_op(req_op), .req_cmd1(req_cmd1), .req_cmd2(req_cmd2), .req_addr(req_addr),
      .dq_out(dq0), .dq_oe(oe0), .cle(cle0), .ale(ale0), .we_n(we_n0), .ce_n(ce_n0),
      .done(done0)
   );

   nand_cmd_seq #(.DW(16), .ADDR_CYCLES(3), .WE_LOW(1), .WE_HIGH(3)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
      .req_op(req_op), .req_cmd1(req_cmd1), .req_cmd2(req_cmd2), .req_addr(req_addr[23:0]),
      .dq_out(dq1), .dq_oe(oe1), .cle(cle1), .ale(ale1), .we_n(we_n1), .ce_n(ce_n1),
      .done(done1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected bus states for one request: each byte occupies wl+wh clocks,
   // followed by a single done cycle.
   function automatic vq_t build(input logic [1:0] op, input logic [7:0] c1,
                                 input logic [7:0] c2, input logic [63:0] addr,
                                 input int ac, input int wl, input int wh);
      vq_t        q;
      logic [7:0] bytes[$];
      bit         is_cmd[$];
      bytes.push_back((op == 2'd3) ? 8'hFF : c1);
      is_cmd.push_back(1'b1);
      if (op == 2'd1 || op == 2'd2) begin
         for (int i = 0; i < ac; i++) begin
            bytes.push_back(addr[8*i +: 8]);
            is_cmd.push_back(1'b0);
         end
      end
      if (op == 2'd2) begin
         bytes.push_back(c2);
         is_cmd.push_back(1'b1);
      end
      for (int b = 0; b < bytes.size(); b++) begin
         for (int t = 0; t < wl + wh; t++) begin
            q.push_back({1'b0, 1'b0, (t >= wl), is_cmd[b], !is_cmd[b], 1'b1, 1'b0,
                         8'h00, bytes[b]});
         end
      end
      q.push_back(DONE_V);
      return q;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q0.delete();
         q1.delete();
         exp0 = IDLE_V;
         exp1 = IDLE_V;
      end else begin
         if (exp0[22] && req_valid)
            q0 = build(req_op, req_cmd1, req_cmd2, {24'h0, req_addr}, 5, 2, 2);
         if (exp1[22] && req_valid)
            q1 = build(req_op, req_cmd1, req_cmd2, {24'h0, req_addr}, 3, 1, 3);
         exp0 = (q0.size() > 0) ? q0.pop_front() : IDLE_V;
         exp1 = (q1.size() > 0) ? q1.pop_front() : IDLE_V;
      end
   end

   always @(negedge clk) begin
      if (run_chk) begin
         check_eq("cyc_dut0", {9'h0, ready0, ce_n0, we_n0, cle0, ale0, oe0, done0, 8'h00, dq0},
                  {9'h0, exp0});
         check_eq("cyc_dut1", {9'h0, ready1, ce_n1, we_n1, cle1, ale1, oe1, done1, dq1},
                  {9'h0, exp1});
      end
   end

   always @(posedge we_n0) lat_q.push_back({cle0, ale0, dq0});

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && exp0[22] && exp1[22]) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("idle_timeout", {31'h0, ok}, 32'h1);
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] c1, input logic [7:0] c2,
                       input logic [39:0] addr, input int hold);
      @(negedge clk);
      req_op    = op;
      req_cmd1  = c1;
      req_cmd2  = c2;
      req_addr  = addr;
      req_valid = 1'b1;
      repeat (hold) @(negedge clk);
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_cmd1  = 8'($urandom);
      req_cmd2  = 8'($urandom);
      req_addr  = {8'($urandom), 32'($urandom)};
      $display("txn op=%0d cmd1=%h cmd2=%h addr=%h hold=%0d", op, c1, c2, addr, hold);
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_chk = 1'b1;

      send(2'd0, 8'h70, 8'h00, 40'h0, 1);
      lat_q.delete();
      send(2'd2, 8'h00, 8'h30, 40'h0302010000, 1);
      begin
         logic [9:0] want [7];
         want = '{{2'b10, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h00}, {2'b01, 8'h01},
                  {2'b01, 8'h02}, {2'b01, 8'h03}, {2'b10, 8'h30}};
         check_eq("latch_count", lat_q.size(), 32'd7);
         for (int i = 0; i < 7; i++)
            check_eq("latch_byte", {22'h0, (i < lat_q.size()) ? lat_q[i] : 10'h3FF},
                     {22'h0, want[i]});
      end
      send(2'd3, 8'h12, 8'h00, 40'h0, 1);

      // Request while busy: different values must be ignored.
      @(negedge clk);
      req_op = 2'd1; req_cmd1 = 8'h80; req_addr = 40'hA4A3A2A1A0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      req_op = 2'd0; req_cmd1 = 8'h5A; req_valid = 1'b1;
      repeat (2) @(negedge clk);
      req_valid = 1'b0;
      $display("txn busy-ignore op=1 cmd1=80 then op=0 cmd1=5a while busy");
      wait_idle();

      send(2'd0, 8'hA5, 8'h00, 40'h0, 14);

      // Reset during the third address byte while WE_n is low.
      @(negedge clk);
      req_op = 2'd1; req_cmd1 = 8'h60; req_addr = 40'h5544332211; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_eq("pre_rst_dut0", {30'h0, we_n0, ale0}, 32'b01);
      check_eq("pre_rst_dut1", {30'h0, we_n1, ale1}, 32'b01);
      rst = 1'b1;
      #1;
      check_eq("rst_async_dut0", {25'h0, we_n0, ce_n0, ale0, cle0, oe0, done0, ready0},
               32'b1100001);
      check_eq("rst_async_dut1", {25'h0, we_n1, ce_n1, ale1, cle1, oe1, done1, ready1},
               32'b1100001);
      check_eq("rst_dq", {8'h0, dq1, dq0}, 32'h0);
      $display("txn reset mid-ADDR");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send(2'd0, 8'h90, 8'h00, 40'h0, 1);

      for (int n = 0; n < 40; n++) begin
         send(2'($urandom), 8'($urandom), 8'($urandom), {8'($urandom), 32'($urandom)},
              int'($urandom_range(1, 8)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nand_cmd_seq.md
# nand_cmd_seq

Parametrised NAND command/address cycle sequencer. It replaces the fixed per-state command byte mux with a self-timed engine. Each accepted request is expanded into a sequence of command and address bus cycles: CLE/ALE qualification, WE_n strobing with programmable low/high widths, chip enable, and LSB-first address serialisation. It sits between the controller top-level FSM, which issues requests, and the NAND I/O pad logic.

## Interface
Parameters:
- DW, 8: NAND data bus width, 8 or 16. Bits above [7:0] are always driven 0.
- ADDR_CYCLES, 5: address bytes per addressed operation, legal range 1..7.
- WE_LOW, 2: clk cycles WE_n is held low per bus cycle, ≥1.
- WE_HIGH, 2: clk cycles WE_n is held high per bus cycle, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle; a request is accepted on req_valid & req_ready.
- req_op  in  2  operation: 0 = CMD1 only; 1 = CMD1 + ADDR; 2 = CMD1 + ADDR + CMD2; 3 = device reset (FFh only).
- req_cmd1  in  8  first command byte, ignored for op 3.
- req_cmd2  in  8  second command byte, used for op 2 only.
- req_addr  in  8*ADDR_CYCLES  address; byte 0 = bits [7:0], sent first.
- dq_out  out  DW  NAND data bus output.
- dq_oe  out  1  output enable for dq pads.
- cle  out  1  command latch enable.
- ale  out  1  address latch enable.
- we_n  out  1  write enable, active-low.
- ce_n  out  1  chip enable, active-low.
- done  out  1  one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, CMD1, ADDR, CMD2, DONE.
- IDLE: req_ready=1, ce_n=1, cle=ale=0, we_n=1, dq_oe=0, dq_out=0.
- On accept, req_op, req_cmd1, req_cmd2 and req_addr are captured into internal registers. Later input changes have no effect.
- Op 3 forces the captured cmd1 to 8'hFF.
- Every bus cycle (one byte) lasts T = WE_LOW + WE_HIGH clocks:
  - we_n=0 for the first WE_LOW clocks, then 1 for WE_HIGH clocks.
  - dq_out, cle, ale and dq_oe=1 are stable for all T clocks. The NAND latches on the we_n rising edge.
- CMD1: cle=1, ale=0, dq_out = cmd1. After one byte: op 0/3 → DONE; op 1/2 → ADDR.
- ADDR: cle=0, ale=1. A byte counter runs 0..ADDR_CYCLES-1, and dq_out = captured addr byte[counter]. After the last byte: op 1 → DONE; op 2 → CMD2.
- CMD2: cle=1, ale=0, dq_out = cmd2. After one byte → DONE.
- DONE (1 clock):
  - done=1, ce_n=1, cle=ale=0, dq_oe=0, dq_out=0, we_n=1, req_ready=0.
  - Next state is IDLE.
- ce_n=0 throughout CMD1/ADDR/CMD2 with no deassertion between bytes.
- req_valid while not in IDLE is ignored: no queuing, no error.

## Timing
- All outputs are registered.
- Reset values: req_ready=1, ce_n=1, we_n=1, cle=0, ale=0, dq_oe=0, dq_out=0, done=0; state IDLE, counters 0.
- Accept at edge k: req_ready=0 and first CMD1 outputs (we_n=0) are visible after edge k. req_ready is 0 from edge k until the DONE→IDLE edge.
- Sequence length in clocks, from the accept edge to the done pulse (inclusive of the done cycle), with N = number of bytes:
  - op 0/3: T+1.
  - op 1: (1+ADDR_CYCLES)·T+1.
  - op 2: (2+ADDR_CYCLES)·T+1.
- req_ready returns to 1 on the clock after done. A back-to-back request is accepted on that cycle at the earliest.
- Byte and phase counters wrap to 0 on each state transition. There is no carry into the next byte.
- Reset mid-sequence: all outputs return immediately (asynchronously) to reset values. we_n is forced high even mid-pulse. The partial sequence is abandoned with no done pulse.

## Test plan
- Reset then idle: hold rst 3 clocks, release → req_ready=1, ce_n=1, we_n=1, cle=ale=0, dq_oe=0, done=0.
- Op 0, cmd1=70h (DW=8, WE_LOW=2, WE_HIGH=2):
  - cle=1 with dq_out=70h for 4 clocks; we_n pattern 0,0,1,1.
  - done pulses 5 clocks after accept.
- Op 2, cmd1=00h, addr=40'h0302010000, cmd2=30h:
  - Bytes observed at we_n rising edges: 00h(cle), 00h, 00h, 01h, 02h, 03h (ale), 30h(cle).
  - done at clock 29.
- Op 3 with req_cmd1=12h: single cle byte FFh, not 12h. done at clock 5.
- Request while busy, plus back-to-back:
  - A second req_valid during op 1 is ignored.
  - A request held on the cycle after done is accepted immediately; ce_n stays high for exactly the DONE and IDLE-accept cycles.
- Reset mid-ADDR (during byte 2, we_n low): rst asserted → we_n=1, ce_n=1, ale=0 without waiting for a clock; no done pulse. After release the next op 0 completes normally. Repeat with DW=16, ADDR_CYCLES=3 and check dq_out[15:8]=0.
